// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Owns the program counter and sequences instruction fetch for the core.
//   A fetch request is raised at the current PC and held until instruction
//   memory acknowledges it. The fetched word then occupies a single execute
//   slot. That slot can be stretched by stall, ended by a trap, or retired
//   normally. On normal retirement the next PC is either pc+4 or an aligned
//   branch/jump target. A misaligned redirect or a trap sends the PC to the
//   trap vector and records the offending PC in trap_epc. A halt request
//   parks the sequencer in HALTED after the current slot retires.
//
// Parameters:
//   RESET_ADDR      PC loaded on reset
//   TRAP_VEC        PC loaded on trap or misaligned redirect
//
// Ports:
//   clk             in   1   clock, rising edge
//   reset_n         in   1   asynchronous reset, active-low
//   imem_req        out  1   fetch request, held until imem_ack
//   imem_addr       out  32  fetch address (always equal to pc)
//   imem_ack        in   1   memory accepted request; data valid this cycle
//   instr_valid     out  1   fetched instruction at pc occupies execute slot
//   stall           in   1   hold current execute slot
//   redirect_valid  in   1   branch/jump taken
//   redirect_addr   in   32  branch/jump target
//   trap            in   1   exception raised by current instruction
//   halt            in   1   enter HALTED after current execute slot
//   resume          in   1   leave HALTED
//   pc              out  32  current PC
//   trap_epc        out  32  PC of last trapping instruction
//   misaligned      out  1   one-cycle pulse: redirect target not aligned
//   instret         out  32  retired-instruction counter
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        trap,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] trap_epc,
    output logic        misaligned,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] trapEpc_q, trapEpc_d;
    logic [31:0] instret_q, instret_d;
    logic        misaligned_q, misaligned_d;

    logic        redirectMisaligned;
    logic [31:0] pcSeq;

    // A redirect is only meaningful when redirect_valid is high; the low two
    // target bits flag a non-word-aligned branch/jump target.
    assign redirectMisaligned = redirect_valid && (redirect_addr[1:0] != 2'b00);

    // Sequential PC; 32-bit addition wraps naturally at the top of memory.
    assign pcSeq = pc_q + 32'd4;

    // State and architectural registers. Reset is asynchronous so that an
    // in-flight fetch request is withdrawn the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_ADDR;
            trapEpc_q    <= 32'd0;
            instret_q    <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            trapEpc_q    <= trapEpc_d;
            instret_q    <= instret_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state logic. Everything holds by default; misaligned defaults low
    // so it can only ever be a single-cycle pulse. Inside EXEC the branches
    // are ordered by priority: trap, stall, misaligned redirect, retirement.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        trapEpc_d    = trapEpc_q;
        instret_d    = instret_q;
        misaligned_d = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // Control inputs are deliberately ignored while fetching.
                if (imem_ack) begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (trap) begin
                    // A trap wins over stall and halt; the faulting
                    // instruction does not retire.
                    trapEpc_d = pc_q;
                    pc_d      = TRAP_VEC;
                    state_d   = S_FETCH;
                end else if (stall) begin
                    state_d = S_EXEC;
                end else if (redirectMisaligned) begin
                    // Treated like a trap on the branch itself, so halt is
                    // not honoured here either.
                    trapEpc_d    = pc_q;
                    pc_d         = TRAP_VEC;
                    misaligned_d = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    pc_d      = redirect_valid ? redirect_addr : pcSeq;
                    instret_d = instret_q + 32'd1;
                    state_d   = halt ? S_HALTED : S_FETCH;
                end
            end

            S_HALTED: begin
                // halt has priority over resume so a held halt line keeps
                // the core parked.
                if (resume && !halt) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Outputs are decoded from state or taken straight from registers, so
    // there is no combinational path from any input to any output.
    assign imem_req    = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign trap_epc    = trapEpc_q;
    assign instret     = instret_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. Every fetch address the bench expects
// the sequencer to request is pushed into a queue before the edge that should
// cause it. A monitor pops the queue whenever a request is accepted and
// compares the addresses. Register values (pc, instret, trap_epc, misaligned,
// state outputs) are checked directly at known points.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        trap;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] trap_epc;
    logic        misaligned;
    logic [31:0] instret;

    int          checkCount = 0;
    int          passCount  = 0;
    int          cycleCount = 0;
    logic [31:0] expFetch[$];

    pc_sequencer #(
        .RESET_ADDR(32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .trap          (trap),
        .halt          (halt),
        .resume        (resume),
        .pc            (pc),
        .trap_epc      (trap_epc),
        .misaligned    (misaligned),
        .instret       (instret)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: an accepted fetch (request and ack both high going
    // into the next edge) must match the oldest expected address.
    always @(negedge clk) begin
        if (reset_n && imem_req && imem_ack) begin
            if (expFetch.size() == 0) begin
                checkOutput("unexpectedFetch", imem_addr, 32'hDEAD_BEEF);
            end else begin
                checkOutput("fetchAddr", imem_addr, expFetch.pop_front());
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait, with a cycle budget, until an instruction occupies the execute slot.
    task automatic waitExec();
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            tick();
        end
        checkOutput("execReached", {31'd0, instr_valid}, 32'd1);
    endtask

    // Drive one set of EXEC-slot controls for a single edge, then clear them.
    task automatic applyStimulus(input logic st, input logic rv,
                                 input logic [31:0] ra, input logic tr,
                                 input logic hl);
        stall          = st;
        redirect_valid = rv;
        redirect_addr  = ra;
        trap           = tr;
        halt           = hl;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        trap           = 1'b0;
        halt           = 1'b0;
    endtask

    initial begin
        int c1;
        int c2;

        reset_n        = 1'b0;
        imem_ack       = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        trap           = 1'b0;
        halt           = 1'b0;
        resume         = 1'b0;
        tick();
        tick();

        // Reset state.
        checkOutput("rstPc",       pc, 32'h0);
        checkOutput("rstReq",      {31'd0, imem_req}, 32'd0);
        checkOutput("rstValid",    {31'd0, instr_valid}, 32'd0);
        checkOutput("rstInstret",  instret, 32'd0);
        checkOutput("rstEpc",      trap_epc, 32'h0);
        checkOutput("rstMisalign", {31'd0, misaligned}, 32'd0);

        // T1: sequential fetch with ack tied high.
        imem_ack = 1'b1;
        expFetch.push_back(32'h0);
        expFetch.push_back(32'h4);
        expFetch.push_back(32'h8);
        expFetch.push_back(32'hC);
        expFetch.push_back(32'h10);
        reset_n = 1'b1;
        checkOutput("bootNoReq", {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput("bootToFetch", {31'd0, imem_req}, 32'd1);
        waitExec();
        checkOutput("t1Pc0", pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1Instret1", instret, 32'd1);
        waitExec();
        c1 = cycleCount;
        checkOutput("t1Pc4", pc, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1Instret2", instret, 32'd2);
        waitExec();
        c2 = cycleCount;
        checkOutput("t1Pc8", pc, 32'h8);
        checkOutput("t1Latency", 32'(c2 - c1), 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1Instret3", instret, 32'd3);
        waitExec();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        waitExec();
        checkOutput("t2Pc10", pc, 32'h10);

        // T2: aligned redirect.
        expFetch.push_back(32'h40);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        checkOutput("t2Addr",    imem_addr, 32'h40);
        checkOutput("t2Req",     {31'd0, imem_req}, 32'd1);
        checkOutput("t2Instret", instret, 32'd5);
        waitExec();
        expFetch.push_back(32'h20);
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        waitExec();
        checkOutput("t3Pc20", pc, 32'h20);

        // T3: misaligned redirect.
        expFetch.push_back(32'h100);
        applyStimulus(1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
        checkOutput("t3Pc",       pc, 32'h100);
        checkOutput("t3Epc",      trap_epc, 32'h20);
        checkOutput("t3MisHigh",  {31'd0, misaligned}, 32'd1);
        checkOutput("t3Instret",  instret, 32'd6);
        tick();
        checkOutput("t3MisLow",   {31'd0, misaligned}, 32'd0);
        checkOutput("t3Exec100",  {31'd0, instr_valid}, 32'd1);

        // T4: stall, then trap during the stall.
        expFetch.push_back(32'h104);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4Instret7", instret, 32'd7);
        waitExec();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4StallPc",    pc, 32'h104);
        checkOutput("t4StallValid", {31'd0, instr_valid}, 32'd1);
        checkOutput("t4StallRet",   instret, 32'd7);
        expFetch.push_back(32'h100);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("t4TrapPc",    pc, 32'h100);
        checkOutput("t4TrapEpc",   trap_epc, 32'h104);
        checkOutput("t4TrapRet",   instret, 32'd7);
        checkOutput("t4TrapReq",   {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4NoHold",    {31'd0, instr_valid}, 32'd1);
        expFetch.push_back(32'h8);
        applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
        waitExec();
        checkOutput("t6Pc8", pc, 32'h8);

        // T6: halt, held halt beats resume, then resume.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t6Pc",      pc, 32'hC);
        checkOutput("t6NoReq",   {31'd0, imem_req}, 32'd0);
        checkOutput("t6NoValid", {31'd0, instr_valid}, 32'd0);
        checkOutput("t6Instret", instret, 32'd9);
        halt   = 1'b1;
        resume = 1'b1;
        tick();
        tick();
        checkOutput("t6HaltWins", {31'd0, imem_req}, 32'd0);
        halt = 1'b0;
        expFetch.push_back(32'hC);
        tick();
        resume = 1'b0;
        checkOutput("t6ResumeReq",  {31'd0, imem_req}, 32'd1);
        checkOutput("t6ResumeAddr", imem_addr, 32'hC);
        waitExec();

        // Trap with halt still goes to FETCH; ack withheld for T5.
        imem_ack = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("trapHaltReq", {31'd0, imem_req}, 32'd1);
        checkOutput("trapHaltPc",  pc, 32'h100);
        checkOutput("trapHaltEpc", trap_epc, 32'hC);

        // T5: stuck fetch, then asynchronous reset mid-cycle.
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("t5StuckReq", {31'd0, imem_req}, 32'd1);
        checkOutput("t5StuckPc",  pc, 32'h100);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t5ReqDrop", {31'd0, imem_req}, 32'd0);
        checkOutput("t5Pc",      pc, 32'h0);
        checkOutput("t5Epc",     trap_epc, 32'h0);
        checkOutput("t5Instret", instret, 32'd0);
        tick();
        reset_n  = 1'b1;
        imem_ack = 1'b1;
        checkOutput("t5Boot", {31'd0, imem_req}, 32'd0);
        expFetch.push_back(32'h0);
        waitExec();

        // PC wrap at the top of the address space.
        expFetch.push_back(32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        waitExec();
        expFetch.push_back(32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("wrapPc",      pc, 32'h0);
        checkOutput("wrapInstret", instret, 32'd2);
        tick();

        checkOutput("queueDrained", 32'(expFetch.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
